// File: rtl/bcd_scan_controller.sv
// Binary-to-BCD converter (serial double-dabble) feeding a
// time-multiplexed 4-position digit scanner with optional blanking.
module bcd_scan_controller #(
    parameter int unsigned REFRESH_DIV   = 50000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd_out,
    output logic [3:0]  digit,
    output logic [3:0]  digit_en
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    state_t      state;
    logic [7:0]  sr;
    logic [11:0] acc;
    logic [2:0]  iter;
    logic [11:0] disp;

    logic [11:0] acc_adj;
    logic [11:0] acc_next;
    logic [7:0]  sr_next;

    always_comb begin
        acc_adj = acc;
        for (int n = 0; n < 3; n++) begin
            if (acc[n*4 +: 4] >= 4'd5)
                acc_adj[n*4 +: 4] = acc[n*4 +: 4] + 4'd3;
        end
        acc_next = {acc_adj[10:0], sr[7]};
        sr_next  = {sr[6:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            disp     <= '0;
            sr       <= '0;
            acc      <= '0;
            iter     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        sr       <= in_data;
                        acc      <= '0;
                        iter     <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc  <= acc_next;
                    sr   <= sr_next;
                    iter <= iter + 3'd1;
                    if (iter == 3'd7) begin
                        // Results land with the COMMIT cycle so done and
                        // bcd_out are valid together.
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        bcd_out <= acc_next;
                        disp    <= acc_next;
                        state   <= COMMIT;
                    end
                end
                COMMIT: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    logic [CW-1:0] refresh_cnt;
    logic [1:0]    scan_idx;
    logic [3:0]    sel_digit;
    logic [3:0]    sel_en;
    logic          h_zero;
    logic          t_zero;

    assign h_zero = (disp[11:8] == 4'd0);
    assign t_zero = (disp[7:4] == 4'd0);

    always_comb begin
        sel_digit = '0;
        sel_en    = '0;
        unique case (scan_idx)
            2'd0: begin
                sel_digit = disp[3:0];
                sel_en    = 4'b0001;
            end
            2'd1: begin
                if (!(BLANK_LEADING && h_zero && t_zero)) begin
                    sel_digit = disp[7:4];
                    sel_en    = 4'b0010;
                end
            end
            2'd2: begin
                if (!(BLANK_LEADING && h_zero)) begin
                    sel_digit = disp[11:8];
                    sel_en    = 4'b0100;
                end
            end
            2'd3: begin
                sel_digit = 4'd0;
                sel_en    = BLANK_LEADING ? 4'b0000 : 4'b1000;
            end
            default: begin
                sel_digit = '0;
                sel_en    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            scan_idx    <= '0;
            digit       <= '0;
            digit_en    <= '0;
        end else begin
            if (refresh_cnt == CNT_MAX) begin
                refresh_cnt <= '0;
                scan_idx    <= scan_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
            digit    <= sel_digit;
            digit_en <= sel_en;
        end
    end

endmodule

// File: tb/tb_bcd_scan_controller.sv
// Directed bench: two instances (div 4 blanking, div 2 no blanking)
// share stimulus; expected values are hand-computed tables.
module tb_bcd_scan_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;

    logic        a_in_ready, a_busy, a_done;
    logic [11:0] a_bcd_out;
    logic [3:0]  a_digit, a_digit_en;
    logic        b_in_ready, b_busy, b_done;
    logic [11:0] b_bcd_out;
    logic [3:0]  b_digit, b_digit_en;

    int checks = 0;
    int failures = 0;
    int ecount = 0;

    always #5 clk = ~clk;

    bcd_scan_controller #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(a_in_ready), .busy(a_busy), .done(a_done),
        .bcd_out(a_bcd_out), .digit(a_digit), .digit_en(a_digit_en)
    );

    bcd_scan_controller #(.REFRESH_DIV(2), .BLANK_LEADING(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(b_in_ready), .busy(b_busy), .done(b_done),
        .bcd_out(b_bcd_out), .digit(b_digit), .digit_en(b_digit_en)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) ecount = 0;
        else ecount++;
    endtask

    task automatic convert(input logic [7:0] v, input logic [11:0] exp);
        int n;
        in_valid = 1'b1;
        in_data  = v;
        tick();
        chk("accept_busy", 16'(a_busy), 16'd1);
        chk("accept_ready", 16'(a_in_ready), 16'd0);
        in_valid = 1'b0;
        in_data  = ~v;
        n = 1;
        while (a_done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("latency", 16'(n), 16'd9);
        chk("bcd_a", 16'(a_bcd_out), 16'(exp));
        chk("bcd_b", 16'(b_bcd_out), 16'(exp));
        chk("done_b", 16'(b_done), 16'd1);
        chk("busy_commit", 16'(a_busy), 16'd0);
        tick();
        chk("ready_after", 16'(a_in_ready), 16'd1);
        chk("done_pulse", 16'(a_done), 16'd0);
    endtask

    // ens/digs hold {pos3,pos2,pos1,pos0} nibbles.
    task automatic scan(input bit sel_b, input int n,
                        input logic [15:0] ens, input logic [15:0] digs);
        int p;
        for (int i = 0; i < n; i++) begin
            tick();
            p = sel_b ? ((ecount - 1) / 2) % 4 : ((ecount - 1) / 4) % 4;
            if (sel_b) begin
                chk("scan_en_b", 16'(b_digit_en), 16'(ens[p*4 +: 4]));
                chk("scan_dig_b", 16'(b_digit), 16'(digs[p*4 +: 4]));
            end else begin
                chk("scan_en_a", 16'(a_digit_en), 16'(ens[p*4 +: 4]));
                chk("scan_dig_a", 16'(a_digit), 16'(digs[p*4 +: 4]));
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        tick();
        chk("rst_ready", 16'(a_in_ready), 16'd0);
        chk("rst_busy", 16'(a_busy), 16'd0);
        chk("rst_done", 16'(a_done), 16'd0);
        chk("rst_bcd", 16'(a_bcd_out), 16'd0);
        chk("rst_en_a", 16'(a_digit_en), 16'd0);
        chk("rst_en_b", 16'(b_digit_en), 16'd0);
        chk("rst_dig", 16'(a_digit), 16'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 16'(a_in_ready), 16'd1);
        chk("post_rst_en_a", 16'(a_digit_en), 16'h1);
        chk("post_rst_en_b", 16'(b_digit_en), 16'h1);
        chk("post_rst_dig", 16'(a_digit), 16'd0);

        convert(8'd255, 12'h255);
        scan(1'b0, 16, 16'h0421, 16'h0255);
        scan(1'b1, 8, 16'h8421, 16'h0255);

        convert(8'd0, 12'h000);
        scan(1'b0, 16, 16'h0001, 16'h0000);

        convert(8'd9, 12'h009);
        scan(1'b1, 8, 16'h8421, 16'h0009);
        scan(1'b0, 16, 16'h0001, 16'h0009);

        convert(8'd100, 12'h100);
        scan(1'b1, 8, 16'h8421, 16'h0100);
        scan(1'b0, 16, 16'h0421, 16'h0100);

        in_valid = 1'b1;
        in_data  = 8'd37;
        tick();
        for (int i = 1; i <= 20; i++) begin
            if (i > 1) tick();
            chk("hold_ready", 16'(a_in_ready),
                (i == 10 || i == 20) ? 16'd1 : 16'd0);
            chk("hold_done", 16'(a_done),
                (i == 9 || i == 19) ? 16'd1 : 16'd0);
            chk("hold_busy", 16'(a_busy),
                ((i >= 1 && i <= 8) || (i >= 11 && i <= 18)) ? 16'd1 : 16'd0);
            if (i == 9) chk("hold_bcd37", 16'(a_bcd_out), 16'h037);
            if (i == 19) chk("hold_bcd128", 16'(a_bcd_out), 16'h128);
            if (i == 1) in_data = 8'd128;
        end
        in_valid = 1'b0;
        tick();

        in_valid = 1'b1;
        in_data  = 8'd200;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_busy", 16'(a_busy), 16'd1);
        rst = 1'b1;
        tick();
        chk("abort_done", 16'(a_done), 16'd0);
        chk("abort_busy", 16'(a_busy), 16'd0);
        chk("abort_bcd", 16'(a_bcd_out), 16'd0);
        chk("abort_en_a", 16'(a_digit_en), 16'd0);
        chk("abort_en_b", 16'(b_digit_en), 16'd0);
        chk("abort_ready", 16'(a_in_ready), 16'd0);
        rst = 1'b0;
        tick();
        chk("rel_en_a", 16'(a_digit_en), 16'h1);
        chk("rel_en_b", 16'(b_digit_en), 16'h1);
        chk("rel_ready", 16'(a_in_ready), 16'd1);
        chk("rel_bcd", 16'(a_bcd_out), 16'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("no_done", 16'(a_done), 16'd0);
        end

        scan(1'b1, 16, 16'h8421, 16'h0000);
        scan(1'b0, 16, 16'h0001, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
